// File: rtl/etherneco_synctimer_scheduler_pkg.sv
// Shared etherneco sync-timer definitions: scheduler states, frame command codes
// and payload layout constants.
package etherneco_synctimer_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_SEND,
      ST_WAIT,
      ST_UPDATE
   } state_t;

   localparam logic [7:0]  CMD_OVERRIDE   = 8'h03;
   localparam logic [7:0]  CMD_ADJUST     = 8'h01;
   localparam int unsigned HEADER_BYTES   = 9;
   localparam int unsigned BYTES_PER_NODE = 4;
   // Byte index width: covers 9 + 4*63 = 261 payload bytes.
   localparam int unsigned IDX_W          = 9;

endpackage

// File: rtl/etherneco_synctimer_offset_table.sv
// Per-node storage: elapsed round-trip times (byte-written from the response
// stream) and the derived one-way offsets (whole-word read for the frame).
module etherneco_synctimer_offset_table #(
   parameter int unsigned MAX_NODES = 8,
   parameter int unsigned NODE_W    = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_wr_en,
   input  logic [NODE_W-1:0] i_wr_node,
   input  logic [1:0]        i_wr_byte,
   input  logic [7:0]        i_wr_data,
   input  logic              i_update,
   input  logic [7:0]        i_update_n,
   input  logic [NODE_W-1:0] i_rd_node,
   output logic [31:0]       o_rd_data_c
);

   logic [31:0] r_elapsed [MAX_NODES];
   logic [31:0] r_offset  [MAX_NODES];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < MAX_NODES; i++) begin
            r_elapsed[i] <= '0;
            r_offset[i]  <= '0;
         end
      end else begin
         if (i_wr_en) begin
            r_elapsed[i_wr_node][{i_wr_byte, 3'b000} +: 8] <= i_wr_data;
         end
         // One-way delay is half the measured round trip, applied to active nodes only.
         if (i_update) begin
            for (int unsigned i = 0; i < MAX_NODES; i++) begin
               if (i < 32'(i_update_n)) begin
                  r_offset[i] <= r_elapsed[i] >> 1;
               end
            end
         end
      end
   end

   assign o_rd_data_c = r_offset[i_rd_node];

endmodule

// File: rtl/etherneco_synctimer_scheduler.sv
// Periodic sync-frame scheduler: requests the transmitter, streams the time and
// per-node offsets, then collects elapsed times from the response to refresh offsets.
module etherneco_synctimer_scheduler
   import etherneco_synctimer_scheduler_pkg::*;
#(
   parameter int unsigned TIMER_WIDTH    = 64,
   parameter int unsigned MAX_NODES      = 8,
   parameter int unsigned PERIOD_WIDTH   = 32,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [PERIOD_WIDTH-1:0] period,
   input  logic [7:0]              node_count,
   input  logic [TIMER_WIDTH-1:0]  current_time,
   output logic                    tx_start,
   input  logic                    tx_ready,
   output logic [15:0]             tx_length,
   output logic [7:0]              m_cmd_data,
   output logic                    m_cmd_first,
   output logic                    m_cmd_last,
   output logic                    m_cmd_valid,
   input  logic                    m_cmd_ready,
   input  logic [15:0]             s_res_pos,
   input  logic [7:0]              s_res_data,
   input  logic                    s_res_valid,
   input  logic                    res_rx_end,
   input  logic                    res_rx_error,
   output logic                    busy,
   output logic [15:0]             timeout_count
);

   localparam int unsigned NODE_W = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
   localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

   state_t                  r_state, w_state_nxt;
   logic [IDX_W-1:0]        r_idx, w_idx_nxt;
   logic [PERIOD_WIDTH-1:0] r_period_cnt;
   logic [WAIT_W-1:0]       r_wait_cnt;
   logic [TIMER_WIDTH-1:0]  r_time;
   logic [7:0]              r_n, r_cmd;
   logic                    r_enable_d, r_first;

   logic                    w_tick, w_first, w_beat, w_timeout_evt, w_res_hit;
   logic [7:0]              w_n_clamp, w_byte_nxt;
   logic [IDX_W-1:0]        w_last_idx, w_off_rel;
   logic [15:0]             w_res_rel;
   logic [63:0]             w_time64;
   logic [2:0]              w_tsel;
   logic [NODE_W-1:0]       w_rd_node;
   logic [31:0]             w_rd_data;

   assign w_tick     = enable && (r_period_cnt == '0);
   assign w_first    = r_first || (enable && !r_enable_d);
   assign w_n_clamp  = (node_count > 8'(MAX_NODES)) ? 8'(MAX_NODES) : node_count;
   assign w_last_idx = IDX_W'(HEADER_BYTES - 1) + (IDX_W'(r_n) << 2);
   assign w_beat     = (r_state == ST_SEND) && m_cmd_ready;

   assign w_timeout_evt = (r_state == ST_WAIT) && enable && !res_rx_error && !res_rx_end
                          && (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

   assign w_res_rel = s_res_pos - 16'(HEADER_BYTES);
   assign w_res_hit = (r_state == ST_WAIT) && s_res_valid
                      && (s_res_pos >= 16'(HEADER_BYTES))
                      && (s_res_pos < (16'(HEADER_BYTES) + (16'(r_n) << 2)));

   // Next-state and byte index.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      case (r_state)
         ST_IDLE: begin
            if (w_tick) w_state_nxt = ST_REQ;
         end
         ST_REQ: begin
            if (!enable) begin
               w_state_nxt = ST_IDLE;
            end else if (tx_start && tx_ready) begin
               w_state_nxt = ST_SEND;
               w_idx_nxt   = '0;
            end
         end
         ST_SEND: begin
            if (w_beat) begin
               if (r_idx == w_last_idx) begin
                  w_state_nxt = enable ? ST_WAIT : ST_IDLE;
               end else begin
                  w_idx_nxt = r_idx + IDX_W'(1);
               end
            end
         end
         ST_WAIT: begin
            if (!enable || res_rx_error) w_state_nxt = ST_IDLE;
            else if (res_rx_end)         w_state_nxt = ST_UPDATE;
            else if (w_timeout_evt)      w_state_nxt = ST_IDLE;
         end
         ST_UPDATE: w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // Payload byte for the next index: cmd, 8 time bytes, then 4 bytes per offset.
   assign w_time64  = 64'(r_time);
   assign w_tsel    = 3'(w_idx_nxt - IDX_W'(1));
   assign w_off_rel = w_idx_nxt - IDX_W'(HEADER_BYTES);
   assign w_rd_node = (w_idx_nxt >= IDX_W'(HEADER_BYTES)) ? NODE_W'(w_off_rel[IDX_W-1:2]) : '0;
   assign w_byte_nxt = (w_idx_nxt == '0)                   ? r_cmd :
                       (w_idx_nxt < IDX_W'(HEADER_BYTES))  ? w_time64[{w_tsel, 3'b000} +: 8] :
                                                             w_rd_data[{w_off_rel[1:0], 3'b000} +: 8];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_IDLE;
         r_idx         <= '0;
         r_period_cnt  <= '0;
         r_wait_cnt    <= '0;
         r_enable_d    <= 1'b0;
         r_first       <= 1'b1;
         r_time        <= '0;
         r_n           <= '0;
         r_cmd         <= '0;
         tx_length     <= '0;
         timeout_count <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_idx      <= w_idx_nxt;
         r_enable_d <= enable;
         if (enable) begin
            if (r_period_cnt == '0) r_period_cnt <= (period == '0) ? '0 : period - PERIOD_WIDTH'(1);
            else                    r_period_cnt <= r_period_cnt - PERIOD_WIDTH'(1);
         end
         // Frame context is frozen at the tick that starts it.
         if ((r_state == ST_IDLE) && w_tick) begin
            r_time    <= current_time;
            r_n       <= w_n_clamp;
            r_cmd     <= w_first ? CMD_OVERRIDE : CMD_ADJUST;
            tx_length <= 16'(HEADER_BYTES) + (16'(w_n_clamp) << 2);
            r_first   <= 1'b0;
         end else if (enable && !r_enable_d) begin
            r_first <= 1'b1;
         end
         r_wait_cnt <= (r_state == ST_WAIT) ? r_wait_cnt + WAIT_W'(1) : '0;
         if (w_timeout_evt && (timeout_count != 16'hFFFF)) begin
            timeout_count <= timeout_count + 16'd1;
         end
      end
   end

   // Registered handshake/stream outputs track the next state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_start    <= 1'b0;
         busy        <= 1'b0;
         m_cmd_valid <= 1'b0;
         m_cmd_first <= 1'b0;
         m_cmd_last  <= 1'b0;
         m_cmd_data  <= '0;
      end else begin
         tx_start    <= (w_state_nxt == ST_REQ);
         busy        <= (w_state_nxt != ST_IDLE);
         m_cmd_valid <= (w_state_nxt == ST_SEND);
         m_cmd_first <= (w_state_nxt == ST_SEND) && (w_idx_nxt == '0);
         m_cmd_last  <= (w_state_nxt == ST_SEND) && (w_idx_nxt == w_last_idx);
         m_cmd_data  <= (w_state_nxt == ST_SEND) ? w_byte_nxt : '0;
      end
   end

   etherneco_synctimer_offset_table #(
      .MAX_NODES (MAX_NODES),
      .NODE_W    (NODE_W)
   ) u_offset_table (
      .clk         (clk),
      .reset       (reset),
      .i_wr_en     (w_res_hit),
      .i_wr_node   (NODE_W'(w_res_rel[15:2])),
      .i_wr_byte   (w_res_rel[1:0]),
      .i_wr_data   (s_res_data),
      .i_update    (r_state == ST_UPDATE),
      .i_update_n  (r_n),
      .i_rd_node   (w_rd_node),
      .o_rd_data_c (w_rd_data)
   );

endmodule

// File: tb/tb_etherneco_synctimer_scheduler.sv
// Scoreboard bench for the sync-timer scheduler: expected payload bytes are queued
// per frame and checked by an independent stream monitor.
module tb_etherneco_synctimer_scheduler;

   typedef struct packed {
      logic [7:0] d;
      logic       f;
      logic       l;
   } beat_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [31:0] period;
   logic [7:0]  node_count;
   logic [63:0] current_time = 64'h1122_3344_5566_7700;
   logic        tx_start;
   logic        tx_ready;
   logic [15:0] tx_length;
   logic [7:0]  m_cmd_data;
   logic        m_cmd_first, m_cmd_last, m_cmd_valid;
   logic        m_cmd_ready;
   logic [15:0] s_res_pos;
   logic [7:0]  s_res_data;
   logic        s_res_valid, res_rx_end, res_rx_error;
   logic        busy;
   logic [15:0] timeout_count;

   beat_t       sb_q[$];
   logic [31:0] exp_off [8];
   logic        tog;
   int          checks = 0;
   int          errors = 0;
   logic [63:0] t0, t5, t6, t_dis, t_en;

   etherneco_synctimer_scheduler #(
      .TIMER_WIDTH    (64),
      .MAX_NODES      (8),
      .PERIOD_WIDTH   (32),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .period        (period),
      .node_count    (node_count),
      .current_time  (current_time),
      .tx_start      (tx_start),
      .tx_ready      (tx_ready),
      .tx_length     (tx_length),
      .m_cmd_data    (m_cmd_data),
      .m_cmd_first   (m_cmd_first),
      .m_cmd_last    (m_cmd_last),
      .m_cmd_valid   (m_cmd_valid),
      .m_cmd_ready   (m_cmd_ready),
      .s_res_pos     (s_res_pos),
      .s_res_data    (s_res_data),
      .s_res_valid   (s_res_valid),
      .res_rx_end    (res_rx_end),
      .res_rx_error  (res_rx_error),
      .busy          (busy),
      .timeout_count (timeout_count)
   );

   always #5 clk = ~clk;

   // Free-running master time: the value seen at a rising edge is what gets latched.
   always @(posedge clk) current_time <= current_time + 64'd1;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic push_frame(input logic [7:0] cmd, input logic [63:0] t, input int n);
      int          total;
      beat_t       e;
      logic [31:0] w;
      total = 9 + 4 * n;
      for (int k = 0; k < total; k++) begin
         if (k == 0)      e.d = cmd;
         else if (k < 9)  e.d = t[8*(k-1) +: 8];
         else begin
            w   = exp_off[(k-9)/4];
            e.d = w[8*((k-9)%4) +: 8];
         end
         e.f = (k == 0);
         e.l = (k == total - 1);
         sb_q.push_back(e);
      end
   endtask

   // Waits until the tick that samples time t, then checks the REQ phase.
   task automatic wait_tick(input string name, input logic [63:0] t, input logic [15:0] len);
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (current_time != t + 64'd1 && n < 400);
      chk({name, "_tx_start"}, tx_start, 1'b1);
      chk({name, "_busy"}, busy, 1'b1);
      chk({name, "_tx_length"}, tx_length, len);
   endtask

   // Returns #1 after the edge that accepts the last byte (first cycle of WAIT).
   task automatic wait_last(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(m_cmd_valid && m_cmd_ready && m_cmd_last) && n < 300);
      if (n >= 300) begin
         checks++;
         errors++;
         $display("FAIL %s_last: no last byte within 300 cycles", name);
      end
      @(posedge clk); #1;
      chk({name, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
   endtask

   task automatic send_resp(input string name, input logic [31:0] e0, input logic [31:0] e1,
                            input logic err, input logic endf);
      logic [63:0] el;
      el = {e1, e0};
      wait_last(name);
      for (int p = 8; p <= 17; p++) begin
         s_res_pos   = 16'(p);
         s_res_valid = 1'b1;
         s_res_data  = (p == 8 || p == 17) ? 8'hEE : el[8*(p-9) +: 8];
         @(posedge clk); #1;
      end
      s_res_valid  = 1'b0;
      res_rx_end   = endf;
      res_rx_error = err;
      @(posedge clk); #1;
      res_rx_end   = 1'b0;
      res_rx_error = 1'b0;
   endtask

   // Stream monitor: every accepted byte is matched against the scoreboard head.
   always @(negedge clk) begin
      beat_t e;
      if (reset && m_cmd_valid && m_cmd_ready) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected: got data=%02h with nothing expected", m_cmd_data);
         end else begin
            e = sb_q.pop_front();
            if ({m_cmd_data, m_cmd_first, m_cmd_last} !== e) begin
               errors++;
               $display("FAIL beat: got data=%02h first=%b last=%b, expected data=%02h first=%b last=%b",
                        m_cmd_data, m_cmd_first, m_cmd_last, e.d, e.f, e.l);
            end
         end
      end
   end

   // Sink ready: always high, or alternating when tog is set.
   initial begin
      m_cmd_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         m_cmd_ready = tog ? ~m_cmd_ready : 1'b1;
      end
   end

   initial begin
      reset = 1'b0; enable = 1'b0; period = 32'd100; node_count = 8'd2;
      tx_ready = 1'b1; tog = 1'b0;
      s_res_pos = '0; s_res_data = '0; s_res_valid = 1'b0;
      res_rx_end = 1'b0; res_rx_error = 1'b0;
      for (int i = 0; i < 8; i++) exp_off[i] = '0;

      repeat (3) @(posedge clk); #1;
      chk("rst_tx_start", tx_start, 1'b0);
      chk("rst_valid", m_cmd_valid, 1'b0);
      chk("rst_first", m_cmd_first, 1'b0);
      chk("rst_last", m_cmd_last, 1'b0);
      chk("rst_data", m_cmd_data, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_timeouts", timeout_count, 16'd0);
      reset = 1'b1;
      repeat (2) @(posedge clk); #1;

      // Frame 1: override, zero offsets; response elapsed {200, 50}
      enable = 1'b1;
      t0 = current_time;
      push_frame(8'h03, t0, 2);
      wait_tick("f1", t0, 16'd17);
      send_resp("f1", 32'd200, 32'd50, 1'b0, 1'b1);

      // Frame 2: adjust with halved elapsed; no response -> timeout
      exp_off[0] = 32'd100;
      exp_off[1] = 32'd25;
      push_frame(8'h01, t0 + 64'd100, 2);
      wait_tick("f2", t0 + 64'd100, 16'd17);
      wait_last("f2");
      repeat (15) @(posedge clk); #1;
      chk("f2_wait_busy", busy, 1'b1);
      @(posedge clk); #1;
      chk("f2_timeout_idle", busy, 1'b0);
      chk("f2_timeout_count", timeout_count, 16'd1);

      // Frame 3: ready toggling; response ends with error and end together
      tog = 1'b1;
      push_frame(8'h01, t0 + 64'd200, 2);
      wait_tick("f3", t0 + 64'd200, 16'd17);
      send_resp("f3", 32'd1000, 32'd2000, 1'b1, 1'b1);
      chk("f3_err_idle", busy, 1'b0);
      tog = 1'b0;

      // Frame 4: offsets untouched by the errored response; disable while waiting
      push_frame(8'h01, t0 + 64'd300, 2);
      wait_tick("f4", t0 + 64'd300, 16'd17);
      wait_last("f4");
      enable = 1'b0;
      t_dis  = current_time;
      @(posedge clk); #1;
      chk("f4_disable_idle", busy, 1'b0);
      repeat (5) @(posedge clk); #1;

      // Frame 5: re-enable resumes the held counter; node_count clamps to 8
      node_count = 8'd200;
      enable = 1'b1;
      t_en = current_time;
      t5 = t_en + 64'd100 - t_dis + (t0 + 64'd300);
      push_frame(8'h03, t5, 8);
      wait_tick("f5", t5, 16'd41);
      for (int n = 0; n < 200 && sb_q.size() > 30; n++) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("rst_mid_valid", m_cmd_valid, 1'b0);
      chk("rst_mid_busy", busy, 1'b0);
      chk("rst_mid_timeouts", timeout_count, 16'd0);
      sb_q.delete();
      for (int i = 0; i < 8; i++) exp_off[i] = '0;
      node_count = 8'd2;
      @(posedge clk); #1;
      reset = 1'b1;

      // Frame 6: first frame after reset is an override with cleared offsets
      t6 = current_time;
      push_frame(8'h03, t6, 2);
      wait_tick("f6", t6, 16'd17);
      wait_last("f6");
      enable = 1'b0;
      @(posedge clk); #1;
      chk("f6_disable_idle", busy, 1'b0);
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
